// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one data-memory port between the CPU load/store
// path and a host/debug port. The CPU wins by default; a wait counter bounds
// how long a pending host request can be blocked. cpu_stall freezes the CPU
// during the single cycle the host owns memory.
// Optional build macro: ARB_STATS_EN adds saturating stall/host-ack counters;
// without it stat_stall_cnt and stat_host_cnt are tied to zero.
module data_mem_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [15:0]       stat_stall_cnt,
  output logic [15:0]       stat_host_cnt
);

  // Wait-counter limit in the counter's own 4-bit width.
  localparam logic [3:0] MAX_WAIT_C = 4'(HOST_MAX_WAIT);

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_WAIT = 2'd1,
    H_ACK  = 2'd2
  } host_state_e;

  host_state_e       state_r;
  host_state_e       state_nxt_s;
  logic [3:0]        wait_cnt_r;
  logic [3:0]        wait_cnt_nxt_s;
  logic              host_grant_s;
  logic              cpu_req_s;
  logic              ack_read_r;
  logic [DATA_W-1:0] host_rdata_r;

  assign cpu_req_s = cpu_mem_read | cpu_mem_write;

  // Host FSM next state, wait counter update and combinational host grant.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    host_grant_s   = 1'b0;
    case (state_r)
      H_IDLE: begin
        if (host_req) begin
          if (cpu_req_s) begin
            wait_cnt_nxt_s = 4'd1;
            state_nxt_s    = H_WAIT;
          end else begin
            host_grant_s = 1'b1;
            state_nxt_s  = H_ACK;
          end
        end else begin
          state_nxt_s = H_IDLE;
        end
      end
      H_WAIT: begin
        if (!cpu_req_s || (wait_cnt_r == MAX_WAIT_C)) begin
          host_grant_s   = 1'b1;
          wait_cnt_nxt_s = 4'd0;
          state_nxt_s    = H_ACK;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + 4'd1;
        end
      end
      H_ACK: begin
        // host_req is deliberately ignored here; a held request restarts next cycle.
        wait_cnt_nxt_s = 4'd0;
        state_nxt_s    = H_IDLE;
      end
      default: begin
        wait_cnt_nxt_s = 4'd0;
        state_nxt_s    = H_IDLE;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= H_IDLE;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Remember whether the granted host transaction is a read, for the ack cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_read_r <= 1'b0;
    end else if (host_grant_s) begin
      ack_read_r <= ~host_we;
    end else begin
      ack_read_r <= ack_read_r;
    end
  end

  // Capture host read data at the end of a read ack; writes leave it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_rdata_r <= '0;
    end else if ((state_r == H_ACK) && ack_read_r) begin
      host_rdata_r <= mem_read_data;
    end else begin
      host_rdata_r <= host_rdata_r;
    end
  end

  // Memory port mux: host when granted, otherwise CPU with store beating load.
  always_comb begin
    mem_address    = cpu_addr;
    mem_write_data = cpu_wdata;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    if (host_grant_s) begin
      mem_address    = host_addr;
      mem_write_data = host_wdata;
      mem_write      = host_we;
      mem_read       = ~host_we;
    end else if (cpu_mem_write) begin
      mem_write = 1'b1;
    end else if (cpu_mem_read) begin
      mem_read = 1'b1;
    end else begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign cpu_stall  = cpu_req_s & host_grant_s;
  assign cpu_rdata  = mem_read_data;
  assign host_ack   = (state_r == H_ACK);
  // During a read ack the fresh memory data is passed straight through.
  assign host_rdata = ((state_r == H_ACK) && ack_read_r) ? mem_read_data : host_rdata_r;

`ifdef ARB_STATS_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] hack_cnt_r;

  // Saturating activity counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 16'd0;
      hack_cnt_r  <= 16'd0;
    end else begin
      if (cpu_stall && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (host_ack && (hack_cnt_r != 16'hFFFF)) begin
        hack_cnt_r <= hack_cnt_r + 16'd1;
      end else begin
        hack_cnt_r <= hack_cnt_r;
      end
    end
  end

  assign stat_stall_cnt = stall_cnt_r;
  assign stat_host_cnt  = hack_cnt_r;
`else
  assign stat_stall_cnt = 16'd0;
  assign stat_host_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios followed by a
// randomized phase, all checked against a transaction-level reference model
// (blocked-cycle count per host transaction plus a reference memory image).
module tb_data_mem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_mem_read, cpu_mem_write;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          host_ack;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data, mem_read_data;
  logic [15:0]   stat_stall_cnt, stat_host_cnt;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOST_MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .stat_stall_cnt(stat_stall_cnt), .stat_host_cnt(stat_host_cnt)
  );

  always #5 clk = ~clk;

  // Data memory device: synchronous write, read data valid the next cycle.
  logic [DW-1:0] dmem [0:65535];
  always @(posedge clk) begin
    if (mem_write) dmem[mem_address] <= mem_write_data;
    if (mem_read)  mem_read_data     <= dmem[mem_address];
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [0:65535];
  bit            m_ack, m_ack_read, m_cpu_rd, last_stall;
  int            m_blocked;
  logic [DW-1:0] m_hrd_val, hold_hrd, m_cpu_val;
  int            cnt_stall, cnt_host;
  int            n_cmp, n_fail;

  // Observations from the most recent step.
  logic          obs_ack, obs_stall, obs_mr, obs_mw;
  logic [DW-1:0] obs_hrd, obs_crd;
  logic [AW-1:0] obs_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] stat_exp(input int cnt);
`ifdef ARB_STATS_EN
    return (cnt > 65535) ? 16'hFFFF : 16'(cnt);
`else
    return 16'd0 + 16'(cnt & 0);
`endif
  endfunction

  task automatic model_reset();
    m_ack = 1'b0; m_ack_read = 1'b0; m_cpu_rd = 1'b0; last_stall = 1'b0;
    m_blocked = 0; hold_hrd = 16'h0000; m_hrd_val = 16'h0000;
    cnt_stall = 0; cnt_host = 0;
  endtask

  // One clock cycle: drive inputs, check against the model, advance the model.
  task automatic step(input bit rd, input bit wr, input logic [15:0] ca, input logic [15:0] cd,
                      input bit hr, input bit hw, input logic [15:0] ha, input logic [15:0] hd);
    bit grant, cpu_req, e_mr, e_mw, e_stall;
    logic [15:0] e_addr, e_wd, e_hrd;
    cpu_mem_read = rd; cpu_mem_write = wr; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    #2;
    cpu_req = rd | wr;
    grant   = !m_ack && hr && (!cpu_req || (m_blocked == MAXW));
    e_addr = ca; e_wd = cd; e_mr = 1'b0; e_mw = 1'b0;
    if (grant) begin
      e_addr = ha; e_wd = hd; e_mw = hw; e_mr = !hw;
    end else if (cpu_req) begin
      e_mw = wr; e_mr = rd && !wr;
    end
    e_stall = cpu_req && grant;
    e_hrd   = (m_ack && m_ack_read) ? m_hrd_val : hold_hrd;
    obs_ack = host_ack; obs_stall = cpu_stall; obs_mr = mem_read; obs_mw = mem_write;
    obs_hrd = host_rdata; obs_crd = cpu_rdata; obs_addr = mem_address;
    chk("mem_read", 32'(mem_read), 32'(e_mr));
    chk("mem_write", 32'(mem_write), 32'(e_mw));
    if (e_mr || e_mw) chk("mem_address", 32'(mem_address), 32'(e_addr));
    if (e_mw) chk("mem_write_data", 32'(mem_write_data), 32'(e_wd));
    chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    chk("host_ack", 32'(host_ack), 32'(m_ack));
    chk("host_rdata", 32'(host_rdata), 32'(e_hrd));
    if (m_cpu_rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_val));
    chk("stat_stall_cnt", 32'(stat_stall_cnt), 32'(stat_exp(cnt_stall)));
    chk("stat_host_cnt", 32'(stat_host_cnt), 32'(stat_exp(cnt_host)));
    @(posedge clk);
    m_cpu_rd  = e_mr && !grant;
    m_cpu_val = ref_mem[ca];
    if (grant && !hw) m_hrd_val = ref_mem[ha];
    if (e_mw) ref_mem[e_addr] = e_wd;
    cnt_stall += int'(e_stall);
    cnt_host  += int'(m_ack);
    if (m_ack) begin
      if (m_ack_read) hold_hrd = m_hrd_val;
      m_ack = 1'b0; m_blocked = 0;
    end else if (hr) begin
      if (grant) begin
        m_ack = 1'b1; m_ack_read = !hw; m_blocked = 0;
      end else begin
        m_blocked++;
      end
    end
    last_stall = e_stall;
    #1;
  endtask

  // Host transaction against a CPU that loads every cycle; reports ack/stall timing.
  task automatic host_contended(input bit hw, input logic [15:0] ha, input logic [15:0] hd,
                                output int ack_at, output int stall_at, output int stalls);
    ack_at = -1; stall_at = -1; stalls = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 16'(i % 16), 16'h0000, !m_ack, hw, ha, hd);
      if (obs_stall) begin
        stalls++;
        if (stall_at < 0) stall_at = i;
      end
      if (obs_ack) begin
        ack_at = i;
        break;
      end
    end
    if (ack_at < 0) chk("host_ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int ack_at, stall_at, stalls;
    bit h_act, h_we, c_rd, c_wr;
    logic [15:0] h_a, h_d, c_a, c_d;
    n_cmp = 0; n_fail = 0;
    model_reset();
    reset = 1'b1;
    cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    host_req = 1'b0; host_we = 1'b0; host_addr = 16'h0000; host_wdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_host_ack", 32'(host_ack), 32'd0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_host_rdata", 32'(host_rdata), 32'd0);
    chk("rst_stat_stall", 32'(stat_stall_cnt), 32'd0);
    chk("rst_stat_host", 32'(stat_host_cnt), 32'd0);
    reset = 1'b0;

    // Preload low addresses through CPU stores.
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, 16'(i), 16'($urandom), 1'b0, 1'b0, 16'h0000, 16'h0000);

    // CPU store then load with an idle host.
    step(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("cpu_store_mw", 32'(obs_mw), 32'd1);
    step(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("cpu_load_data", 32'(obs_crd), 32'h0000BEEF);

    // Uncontended host write then read.
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1234);
    chk("hwr_grant_addr", 32'(obs_addr), 32'h00000020);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("hwr_ack", 32'(obs_ack), 32'd1);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("hrd_ack_data", 32'(obs_hrd), 32'h00001234);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("hrd_held", 32'(obs_hrd), 32'h00001234);

    // Host blocked by a CPU requesting every cycle.
    host_contended(1'b0, 16'h0003, 16'h0000, ack_at, stall_at, stalls);
    chk("wait_ack_cycle", 32'(ack_at), 32'(MAXW + 1));
    chk("wait_stall_cycle", 32'(stall_at), 32'(MAXW));
    chk("wait_stall_count", 32'(stalls), 32'd1);

    // Store and load together: store wins.
    step(1'b1, 1'b1, 16'h0005, 16'hA5A5, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("both_mw", 32'(obs_mw), 32'd1);
    chk("both_mr", 32'(obs_mr), 32'd0);

    // Reset while the host has been blocked for three cycles.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'h0007, 16'h7777);
    cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; host_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_host_ack", 32'(host_ack), 32'd0);
    chk("midrst_cpu_stall", 32'(cpu_stall), 32'd0);
    chk("midrst_host_rdata", 32'(host_rdata), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("post_rst_no_ack", 32'(obs_ack), 32'd0);
    end

    // Three contended transactions; the first also proves the wait counter restarted.
    for (int t = 0; t < 3; t++) begin
      host_contended(t[0], 16'(8 + t), 16'(16'h0100 + t), ack_at, stall_at, stalls);
      chk("contended_ack_cycle", 32'(ack_at), 32'(MAXW + 1));
    end
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
`ifdef ARB_STATS_EN
    chk("stats_host_3", 32'(obs_ack) + 32'(stat_host_cnt), 32'd3);
    chk("stats_stall_3", 32'(stat_stall_cnt), 32'd3);
`else
    chk("stats_host_off", 32'(stat_host_cnt), 32'd0);
    chk("stats_stall_off", 32'(stat_stall_cnt), 32'd0);
`endif

    // Randomized traffic on both ports.
    h_act = 1'b0; h_we = 1'b0; h_a = 16'h0000; h_d = 16'h0000;
    c_rd = 1'b0; c_wr = 1'b0; c_a = 16'h0000; c_d = 16'h0000;
    for (int i = 0; i < 400; i++) begin
      if (m_ack) begin
        h_act = 1'b0;
      end else if (!h_act && ($urandom_range(0, 3) == 0)) begin
        h_act = 1'b1; h_we = 1'($urandom_range(0, 1));
        h_a = 16'($urandom_range(0, 15)); h_d = 16'($urandom);
      end
      if (!last_stall) begin
        case ($urandom_range(0, 3))
          0: begin c_rd = 1'b0; c_wr = 1'b0; end
          1: begin c_rd = 1'b1; c_wr = 1'b0; end
          2: begin c_rd = 1'b0; c_wr = 1'b1; end
          default: begin c_rd = 1'b1; c_wr = 1'b1; end
        endcase
        c_a = 16'($urandom_range(0, 15)); c_d = 16'($urandom);
      end
      step(c_rd, c_wr, c_a, c_d, h_act && !m_ack, h_we, h_a, h_d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
